// File: rtl/dp_table_pkg.sv
// Shared types and defaults for the chain-multiplier DP cost/split table.
package dp_table_pkg;

  localparam int N_MAX_DEF  = 31;
  localparam int COST_W_DEF = 32;
  localparam int IDX_W_DEF  = 5;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    DUMP  = 2'd2
  } state_e;

  function automatic logic [31:0] addr(input logic [31:0] i, input logic [31:0] j,
                                       input logic [31:0] n_max);
    return i * n_max + j;
  endfunction

endpackage

// File: rtl/dp_table_mem_if.sv
// Bus bundle between the DP engine / output stage and the cost/split table.
interface dp_table_mem_if
  import dp_table_pkg::*;
#(
  parameter int COST_W = COST_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
);

  logic              clr_start;
  logic              busy;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_i, wr_j;
  logic [COST_W-1:0] wr_cost;
  logic [IDX_W-1:0]  wr_split;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_i, rd_k, rd_j;
  logic              rd_valid;
  logic [COST_W-1:0] cost_ik, cost_k1j;
  logic              dump_start;
  logic [IDX_W:0]    dump_n;
  logic              dump_valid;
  logic              dump_ready;
  logic [IDX_W-1:0]  dump_i, dump_j;
  logic [COST_W-1:0] dump_cost;
  logic [IDX_W-1:0]  dump_split;
  logic              dump_last;

  modport master (
    output clr_start, wr_en, wr_i, wr_j, wr_cost, wr_split,
           rd_en, rd_i, rd_k, rd_j, dump_start, dump_n, dump_ready,
    input  busy, rd_valid, cost_ik, cost_k1j,
           dump_valid, dump_i, dump_j, dump_cost, dump_split, dump_last
  );

  modport slave (
    input  clr_start, wr_en, wr_i, wr_j, wr_cost, wr_split,
           rd_en, rd_i, rd_k, rd_j, dump_start, dump_n, dump_ready,
    output busy, rd_valid, cost_ik, cost_k1j,
           dump_valid, dump_i, dump_j, dump_cost, dump_split, dump_last
  );

endinterface

// File: rtl/dp_tri_iter.sv
// Upper-triangle (i,j) walker: row-major, j starts at i on every row.
module dp_tri_iter #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W:0]   n,
  input  logic             advance,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [IDX_W:0]   n_q, n_d;
  logic             end_row;

  assign end_row = ({1'b0, j_q} == n_q - 1'b1);
  assign last    = end_row && ({1'b0, i_q} == n_q - 1'b1);
  assign i       = i_q;
  assign j       = j_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    n_d = n_q;
    if (load) begin
      i_d = '0;
      j_d = '0;
      n_d = n;
    end else if (advance && !last) begin
      if (end_row) begin
        i_d = i_q + 1'b1;
        j_d = i_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      n_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      n_q <= n_d;
    end
  end

endmodule

// File: rtl/dp_table_mem.sv
// Cost/split table with clear engine, dual-operand read and triangular dump port.
module dp_table_mem
  import dp_table_pkg::*;
#(
  parameter int N_MAX  = N_MAX_DEF,
  parameter int COST_W = COST_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  dp_table_mem_if.slave bus
);

  localparam int                DEPTH    = N_MAX * N_MAX;
  localparam int                ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W:0]    NMAX     = (IDX_W + 1)'(N_MAX);

  logic [COST_W-1:0] cost_mem  [DEPTH];
  logic [IDX_W-1:0]  split_mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rd_valid_q;
  logic [COST_W-1:0] cost_ik_q, cost_k1j_q;

  logic              acc_ok, clr_we, it_load, it_adv, it_last, in_dump;
  logic [IDX_W-1:0]  it_i, it_j;
  logic [IDX_W:0]    dump_n_c, k1;
  logic              wr_hit, rd_ik_ok, rd_k1j_ok;
  logic [ADDR_W-1:0] wr_a, ik_a, k1j_a, dump_a;

  assign dump_n_c  = (bus.dump_n > NMAX) ? NMAX : bus.dump_n;
  assign k1        = {1'b0, bus.rd_k} + 1'b1;
  // Range guards also stop out-of-range columns from aliasing into the next row.
  assign wr_hit    = ({1'b0, bus.wr_i} < NMAX) && ({1'b0, bus.wr_j} < NMAX);
  assign rd_ik_ok  = ({1'b0, bus.rd_i} < NMAX) && ({1'b0, bus.rd_k} < NMAX);
  assign rd_k1j_ok = (k1 < NMAX) && ({1'b0, bus.rd_j} < NMAX);

  assign wr_a   = ADDR_W'(addr(32'(bus.wr_i), 32'(bus.wr_j), 32'(N_MAX)));
  assign ik_a   = ADDR_W'(addr(32'(bus.rd_i), 32'(bus.rd_k), 32'(N_MAX)));
  assign k1j_a  = ADDR_W'(addr(32'(k1), 32'(bus.rd_j), 32'(N_MAX)));
  assign dump_a = ADDR_W'(addr(32'(it_i), 32'(it_j), 32'(N_MAX)));

  dp_tri_iter #(.IDX_W(IDX_W)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (it_load),
    .n       (dump_n_c),
    .advance (it_adv),
    .i       (it_i),
    .j       (it_j),
    .last    (it_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end
      end
      IDLE: begin
        if (bus.clr_start)                           state_d = CLEAR;
        else if (bus.dump_start && dump_n_c != '0)   state_d = DUMP;
      end
      DUMP: begin
        if (bus.dump_ready && it_last) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    in_dump = (state_q == DUMP);
    clr_we  = (state_q == CLEAR);
    acc_ok  = (state_q == IDLE) && !bus.clr_start && !bus.dump_start;
    it_load = (state_q == IDLE) && !bus.clr_start && bus.dump_start;
    it_adv  = in_dump && bus.dump_ready;
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      cost_mem[clr_cnt_q]  <= '0;
      split_mem[clr_cnt_q] <= '0;
    end else if (acc_ok && bus.wr_en && wr_hit) begin
      cost_mem[wr_a]  <= bus.wr_cost;
      split_mem[wr_a] <= bus.wr_split;
    end
  end

  // Operand read stage: sampled from pre-write array contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      cost_ik_q  <= '0;
      cost_k1j_q <= '0;
    end else begin
      rd_valid_q <= acc_ok && bus.rd_en;
      if (acc_ok && bus.rd_en) begin
        cost_ik_q  <= rd_ik_ok  ? cost_mem[ik_a]  : '0;
        cost_k1j_q <= rd_k1j_ok ? cost_mem[k1j_a] : '0;
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.cost_ik    = cost_ik_q;
  assign bus.cost_k1j   = cost_k1j_q;
  assign bus.dump_valid = in_dump;
  assign bus.dump_last  = in_dump && it_last;
  assign bus.dump_i     = in_dump ? it_i : '0;
  assign bus.dump_j     = in_dump ? it_j : '0;
  assign bus.dump_cost  = in_dump ? cost_mem[dump_a]  : '0;
  assign bus.dump_split = in_dump ? split_mem[dump_a] : '0;

endmodule

// File: tb/tb_dp_table_mem.sv
// Randomized self-checking bench for dp_table_mem against a 2-D array model.
module tb_dp_table_mem;

  localparam int N  = 31;
  localparam int CW = 32;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dp_table_mem_if #(.COST_W(CW), .IDX_W(IW)) bus ();

  dp_table_mem #(.N_MAX(N), .COST_W(CW), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0] m_ref [N][N];
  logic [IW-1:0] s_ref [N][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m_ref[i][j] = '0;
        s_ref[i][j] = '0;
      end
  endtask

  task automatic idle_inputs();
    bus.clr_start = 0; bus.wr_en = 0; bus.rd_en = 0; bus.dump_start = 0;
    bus.dump_ready = 0; bus.wr_i = 0; bus.wr_j = 0; bus.wr_cost = 0; bus.wr_split = 0;
    bus.rd_i = 0; bus.rd_k = 0; bus.rd_j = 0; bus.dump_n = 0;
  endtask

  task automatic wait_clear(input string tag);
    int cyc = 0;
    while (bus.busy === 1'b1 && cyc < 2000) begin
      step();
      cyc++;
    end
    check(tag, 64'(cyc), 64'(N * N));
    clear_ref();
  endtask

  // One cycle with an optional write and an optional operand read.
  task automatic access(input logic we, input int wi, input int wj, input logic [CW-1:0] wc,
                        input int ws, input logic re, input int ri, input int rk, input int rj);
    logic [CW-1:0] e_ik, e_k1j;
    e_ik = '0;
    e_k1j = '0;
    if (ri < N && rk < N) e_ik = m_ref[ri][rk];
    if (rk + 1 < N && rj < N) e_k1j = m_ref[rk + 1][rj];
    bus.wr_en = we; bus.wr_i = IW'(wi); bus.wr_j = IW'(wj);
    bus.wr_cost = wc; bus.wr_split = IW'(ws);
    bus.rd_en = re; bus.rd_i = IW'(ri); bus.rd_k = IW'(rk); bus.rd_j = IW'(rj);
    step();
    bus.wr_en = 0;
    bus.rd_en = 0;
    if (we && wi < N && wj < N) begin
      m_ref[wi][wj] = wc;
      s_ref[wi][wj] = IW'(ws);
    end
    check("rd_valid", 64'(bus.rd_valid), 64'(re));
    if (re) begin
      check("cost_ik", 64'(bus.cost_ik), 64'(e_ik));
      check("cost_k1j", 64'(bus.cost_k1j), 64'(e_k1j));
    end
  endtask

  task automatic wr(input int i, input int j, input logic [CW-1:0] c, input int s);
    access(1'b1, i, j, c, s, 1'b0, 0, 0, 0);
  endtask

  task automatic rd(input int i, input int k, input int j);
    access(1'b0, 0, 0, '0, 0, 1'b1, i, k, j);
  endtask

  function automatic int rnd_idx();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 7));
  endfunction

  // mode 0: ready held high, 1: ready toggles 1,0,1,..., 2: random ready.
  task automatic run_dump(input int n_req, input int mode, input int abort_at);
    int n, total, b, cyc, ei, ej;
    logic rdy, stalled;
    logic [63:0] snap, prev;
    n = (n_req > N) ? N : n_req;
    total = n * (n + 1) / 2;
    b = 0; cyc = 0; ei = 0; ej = 0; stalled = 0; prev = '0;
    bus.dump_n = (IW + 1)'(n_req);
    bus.dump_start = 1;
    step();
    bus.dump_start = 0;
    check("dump_busy", 64'(bus.busy), 64'(1));
    while (b < total && cyc < 4 * total + 20) begin
      if (b == abort_at) begin
        bus.dump_ready = 0;
        #2 rst = 1;
        #1;
        check("abort_valid", 64'(bus.dump_valid), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(1));
        return;
      end
      check("dump_valid", 64'(bus.dump_valid), 64'(1));
      check("dump_i", 64'(bus.dump_i), 64'(ei));
      check("dump_j", 64'(bus.dump_j), 64'(ej));
      check("dump_cost", 64'(bus.dump_cost), 64'(m_ref[ei][ej]));
      check("dump_split", 64'(bus.dump_split), 64'(s_ref[ei][ej]));
      check("dump_last", 64'(bus.dump_last), 64'(ei == n - 1 && ej == n - 1));
      snap = {22'd0, bus.dump_i, bus.dump_j, bus.dump_cost};
      if (stalled) check("dump_hold", snap, prev);
      prev = snap;
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 2 == 0);
      else                rdy = 1'($urandom_range(0, 1));
      bus.dump_ready = rdy;
      if (cyc == 0) begin
        // Accesses during DUMP must be ignored.
        bus.wr_en = 1; bus.wr_i = 0; bus.wr_j = 0; bus.wr_cost = 32'hDEAD;
        bus.rd_en = 1; bus.rd_i = 0; bus.rd_k = 0; bus.rd_j = 0;
      end
      step();
      if (cyc == 0) begin
        bus.wr_en = 0;
        bus.rd_en = 0;
        check("busy_rd_valid", 64'(bus.rd_valid), 64'(0));
      end
      cyc++;
      if (rdy) begin
        b++;
        if (ej == n - 1) begin
          ei++;
          ej = ei;
        end else begin
          ej++;
        end
        stalled = 0;
      end else begin
        stalled = 1;
      end
    end
    bus.dump_ready = 0;
    check("dump_beats", 64'(b), 64'(total));
    check("dump_end_valid", 64'(bus.dump_valid), 64'(0));
    check("dump_end_busy", 64'(bus.busy), 64'(0));
    if (mode == 0) check("dump_cycles", 64'(cyc), 64'(total));
  endtask

  initial begin
    idle_inputs();
    clear_ref();
    #3 rst = 1;
    #1;
    check("rst_busy", 64'(bus.busy), 64'(1));
    check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
    check("rst_dump_valid", 64'(bus.dump_valid), 64'(0));
    check("rst_dump_last", 64'(bus.dump_last), 64'(0));
    check("rst_cost_ik", 64'(bus.cost_ik), 64'(0));
    check("rst_cost_k1j", 64'(bus.cost_k1j), 64'(0));
    check("rst_dump_cost", 64'(bus.dump_cost), 64'(0));
    step();
    step();
    rst = 0;
    wait_clear("reset_clear_cycles");

    rd(5, 7, 9);
    wr(2, 4, 100, 3);
    wr(5, 9, 250, 4);
    rd(2, 4, 9);
    wr(1, 1, 7, 0);
    access(1'b1, 1, 1, 9, 2, 1'b1, 1, 1, 0);
    rd(1, 1, 0);
    wr(30, 30, 5, 1);
    rd(30, 30, 30);
    wr(0, 31, 77, 6);
    rd(1, 0, 0);
    step();
    check("rd_hold_ik", 64'(bus.cost_ik), 64'(m_ref[1][0]));
    check("rd_hold_valid", 64'(bus.rd_valid), 64'(0));

    for (int t = 0; t < 300; t++)
      access(1'($urandom_range(0, 1)), rnd_idx(), rnd_idx(), $urandom(), int'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), rnd_idx(), rnd_idx(), rnd_idx());

    for (int i = 0; i < 5; i++)
      for (int j = i; j < 5; j++)
        wr(i, j, $urandom(), int'($urandom_range(0, 31)));

    run_dump(3, 1, -1);
    rd(0, 0, 0);

    bus.dump_n = 0;
    bus.dump_start = 1;
    step();
    bus.dump_start = 0;
    for (int t = 0; t < 4; t++) begin
      check("dump0_valid", 64'(bus.dump_valid), 64'(0));
      check("dump0_busy", 64'(bus.busy), 64'(0));
      step();
    end

    run_dump(40, 0, -1);
    run_dump(5, 2, -1);

    wr(3, 3, 1234, 5);
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    wait_clear("clr_start_cycles");
    rd(3, 2, 3);

    for (int i = 0; i < 4; i++)
      for (int j = i; j < 4; j++)
        wr(i, j, $urandom(), int'($urandom_range(0, 31)));
    run_dump(3, 0, 3);
    step();
    rst = 0;
    wait_clear("abort_clear_cycles");
    rd(0, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
